// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and subordinate FSM state type.
package ahb_pkg;

  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_BUSY   = 2'b01;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_SEQ    = 2'b11;

  localparam logic AHB_OKAY  = 1'b0;
  localparam logic AHB_ERROR = 1'b1;

  typedef enum logic [1:0] {READY, WAIT, ERR1, ERR2} ahbsub_state_t;

  // True when the low address bits are not a multiple of 2^size.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = lo[0];
      3'd2:    bad = |lo[1:0];
      default: bad = |lo[2:0];
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-strobed single-port RAM: asynchronous read, synchronous write.
module ahb_sram_array #(
  parameter int XLEN       = 64,
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [XLEN/8-1:0]     be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB-Lite SRAM subordinate with wait states and two-cycle ERROR response.
// Optional macro AHBSRAM_BURST_FAST_EN: SEQ beats skip the wait states.
module ahb_sram_sub
  import ahb_pkg::*;
#(
  parameter int PA_BITS        = 34,
  parameter int XLEN           = 64,
  parameter int RAM_BYTES_LOG2 = 16,
  parameter int WAIT_STATES    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [XLEN-1:0]     HWDATA,
  input  logic [XLEN/8-1:0]   HWSTRB,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [XLEN-1:0]     HRDATA
);

  localparam int BYTE_LOG2 = $clog2(XLEN/8);
  localparam int IDX_W     = RAM_BYTES_LOG2 - BYTE_LOG2;

  // Handshake: a transfer is accepted when HSEL & HTRANS[1] & HREADY at a
  // rising edge; its data phase completes at the first edge with HREADYOUT=1.
  ahbsub_state_t    state;
  logic [3:0]       wait_cnt;
  logic             dp_active;
  logic             dp_write;
  logic [IDX_W-1:0] dp_index;

  logic             accept;
  logic             addr_err;
  logic             need_wait;
  logic             ram_we;
  logic [XLEN-1:0]  ram_rdata;
  logic             unused;

  assign accept   = HSEL & HTRANS[1] & HREADY & HREADYOUT;
  assign addr_err = (HSIZE > 3'(BYTE_LOG2)) | is_misaligned(HSIZE, HADDR[2:0]);

`ifdef AHBSRAM_BURST_FAST_EN
  assign need_wait = (WAIT_STATES != 0) && (HTRANS == AHB_NONSEQ);
`else
  assign need_wait = (WAIT_STATES != 0);
`endif

  // Upper address bits alias the RAM; HBURST is informational only.
  assign unused = ^{HBURST, HADDR[PA_BITS-1:RAM_BYTES_LOG2]};

  assign HREADYOUT = (state == READY) || (state == ERR2);
  assign HRESP     = ((state == ERR1) || (state == ERR2)) ? AHB_ERROR : AHB_OKAY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= READY;
      wait_cnt  <= '0;
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_index  <= '0;
    end else begin
      case (state)
        READY, ERR2: begin
          state     <= READY;
          dp_active <= 1'b0;
          if (accept) begin
            dp_write <= HWRITE;
            dp_index <= HADDR[RAM_BYTES_LOG2-1:BYTE_LOG2];
            if (addr_err) begin
              state <= ERR1;
            end else begin
              dp_active <= 1'b1;
              if (need_wait) begin
                state    <= WAIT;
                wait_cnt <= 4'(WAIT_STATES - 1);
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= READY;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ERR1:    state <= ERR2;
        default: state <= READY;
      endcase
    end
  end

  // Writes commit on the completion edge, so a following read sees them.
  assign ram_we = dp_active & dp_write & (state == READY);

  ahb_sram_array #(
    .XLEN       (XLEN),
    .DEPTH_LOG2 (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (HWSTRB),
    .addr  (dp_index),
    .wdata (HWDATA),
    .rdata (ram_rdata)
  );

  assign HRDATA = (dp_active && !dp_write) ? ram_rdata : '0;

endmodule
